// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory (slave).
// Handshake: mem_ready is a completion strobe; an access finishes in the cycle it is high.
interface multicycle_controller_if #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [WORD_WIDTH-1:0] inst;
  logic                  alu_zero;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic [1:0]            reg_dst;
  logic [1:0]            mem_to_reg;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic                  imm_zext;
  logic [3:0]            alusel;
  logic [1:0]            pc_source;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  instr_count;
  logic [3:0]            state;

  modport master (
    input  inst, alu_zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alusel,
           pc_source, illegal, instr_count, state
  );

  modport slave (
    output inst, alu_zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alusel,
           pc_source, illegal, instr_count, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS-subset datapath, with a retired-instruction
// counter and illegal-encoding detection.
module multicycle_controller #(
  parameter int WORD_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
    S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
    S_JAL = 4'd12, S_JR = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0001, ALU_SUB = 4'b0011, ALU_AND = 4'b0111,
                         ALU_OR  = 4'b1111, ALU_XOR = 4'b0110, ALU_SLT = 4'b1110,
                         ALU_SLL = 4'b1100, ALU_SRL = 4'b1000;

  state_t               st, st_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 retire;
  logic [5:0]           op, fn;
  logic                 rdy;

  assign op  = bus.inst[WORD_WIDTH-1 -: 6];
  assign fn  = bus.inst[5:0];
  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_FETCH;
      cnt <= '0;
    end else begin
      st <= st_nx;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  assign bus.state       = rst ? 4'd0 : st;
  assign bus.instr_count = rst ? '0 : cnt;

  always_comb begin
    st_nx          = st;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.imm_zext   = 1'b0;
    bus.alusel     = 4'b0000;
    bus.pc_source  = 2'b00;
    bus.illegal    = 1'b0;
    case (st)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alusel    = ALU_ADD;
        bus.ir_write  = rdy;
        bus.pc_write  = rdy;
        if (rdy) st_nx = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is dispatched.
        bus.alu_src_b = 2'b11;
        bus.alusel    = ALU_ADD;
        case (op)
          6'h23, 6'h2B: st_nx = S_MEMADDR;
          6'h00: begin
            case (fn)
              6'h08: st_nx = S_JR;
              6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h2A: st_nx = S_REXEC;
              default: begin
                bus.illegal = 1'b1;
                st_nx       = S_FETCH;
              end
            endcase
          end
          6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A: st_nx = S_IEXEC;
          6'h04, 6'h05: st_nx = S_BRANCH;
          6'h02: st_nx = S_JUMP;
          6'h03: st_nx = S_JAL;
          default: begin
            bus.illegal = 1'b1;
            st_nx       = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.alusel    = ALU_ADD;
        st_nx         = (op == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        if (rdy) st_nx = S_MEMWB;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (rdy) begin
          st_nx  = S_FETCH;
          retire = 1'b1;
        end
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        st_nx          = S_FETCH;
        retire         = 1'b1;
      end
      S_REXEC: begin
        bus.alu_src_a = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
        case (fn)
          6'h20:   bus.alusel = ALU_ADD;
          6'h22:   bus.alusel = ALU_SUB;
          6'h24:   bus.alusel = ALU_AND;
          6'h25:   bus.alusel = ALU_OR;
          6'h26:   bus.alusel = ALU_XOR;
          6'h2A:   bus.alusel = ALU_SLT;
          6'h00:   bus.alusel = ALU_SLL;
          6'h02:   bus.alusel = ALU_SRL;
          default: bus.alusel = 4'b0000;
        endcase
        st_nx = S_RWB;
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        st_nx         = S_FETCH;
        retire        = 1'b1;
      end
      S_IEXEC: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.imm_zext  = (op == 6'h0C || op == 6'h0D);
        case (op)
          6'h0C:   bus.alusel = ALU_AND;
          6'h0D:   bus.alusel = ALU_OR;
          6'h0A:   bus.alusel = ALU_SLT;
          default: bus.alusel = ALU_ADD;
        endcase
        st_nx = S_IWB;
      end
      S_IWB: begin
        bus.reg_write = 1'b1;
        st_nx         = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b01;
        bus.alusel    = ALU_SUB;
        bus.pc_source = 2'b01;
        bus.pc_write  = (op == 6'h05) ? ~bus.alu_zero : bus.alu_zero;
        st_nx         = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        st_nx         = S_FETCH;
        retire        = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced in FETCH, so the link value is PC+4.
        bus.pc_source  = 2'b10;
        bus.pc_write   = 1'b1;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        st_nx          = S_FETCH;
        retire         = 1'b1;
      end
      S_JR: begin
        bus.pc_source = 2'b11;
        bus.pc_write  = 1'b1;
        st_nx         = S_FETCH;
        retire        = 1'b1;
      end
      default: st_nx = S_FETCH;
    endcase
    if (rst) begin
      st_nx          = S_FETCH;
      retire         = 1'b0;
      bus.pc_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 2'b00;
      bus.mem_to_reg = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.imm_zext   = 1'b0;
      bus.alusel     = 4'b0000;
      bus.pc_source  = 2'b00;
      bus.illegal    = 1'b0;
    end
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state control unit for the multicycle MIPS-subset datapath, the successor to the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. Memory accesses use a ready handshake, so variable-latency instruction/data memory is supported. It also counts retired instructions and flags illegal encodings.

## Interface
- `WORD_WIDTH`, 32: instruction width; `inst` is this wide.
- `CNT_WIDTH`, 32: width of the retired-instruction counter.
- `MEM_HANDSHAKE`, 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constant 1.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `inst` in WORD_WIDTH: instruction register contents, valid from DECODE onward.
- `alu_zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes in the cycle it is high.
- `pc_write` out 1: load PC this cycle.
- `iord` out 1: memory address source, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory request.
- `ir_write` out 1: load the instruction register.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 2: write register, 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: write data, 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 2: 00 = PC, 01 = reg A, 10 = zero-extended shamt.
- `alu_src_b` out 2: 00 = reg B, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- `imm_zext` out 1: extended imm is zero-extended (andi, ori); otherwise sign-extended.
- `alusel` out 4: ADD 0001, SUB 0011, AND 0111, OR 1111, XOR 0110, SLT 1110, SLL 1100, SRL 1000; default 0000.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], imm26, 00}, 11 = reg A.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `instr_count` out CNT_WIDTH: retired-instruction counter.
- `state` out 4: current state, for debug.

## Operation
- State encodings:
  - FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7
  - IEXEC 8, IWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13.
- Outputs are Moore-style from `state`, with `inst` and `alu_zero` as extra inputs. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, ADD, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE:
  - Drives `alu_src_a`=00, `alu_src_b`=11, ADD, which precomputes the branch target into ALUOut.
  - Dispatches on the opcode:
    - lw/sw → MEMADDR
    - R-type → REXEC, except funct 08 → JR
    - addi/addiu/andi/ori/slti → IEXEC
    - beq/bne → BRANCH
    - j → JUMP
    - jal → JAL
    - anything else → `illegal`=1, then FETCH.
  - An R-type funct outside {20, 22, 24, 25, 26, 00, 02, 2A, 08} is illegal.
- MEMADDR: `alu_src_a`=01, `alu_src_b`=10, ADD; next state MEMRD (lw) or MEMWR (sw).
- MEMRD / MEMWR:
  - Drive `iord`=1 and `mem_read` or `mem_write`=1 respectively.
  - The request is held stable until `mem_ready`=1.
  - On completion: MEMRD → MEMWB; MEMWR → FETCH.
- MEMWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01.
- REXEC:
  - `alusel` from funct.
  - sll/srl: `alu_src_a`=10, `alu_src_b`=00.
  - All other functs: `alu_src_a`=01, `alu_src_b`=00.
- RWB: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00.
- IEXEC:
  - `alu_src_a`=01, `alu_src_b`=10.
  - `alusel`: ADD for addi/addiu, AND for andi, OR for ori, SLT for slti.
  - `imm_zext`=1 for andi/ori.
- IWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00.
- BRANCH:
  - `alu_src_a`=01, `alu_src_b`=00, SUB, `pc_source`=01.
  - `pc_write` = `alu_zero` for beq, !`alu_zero` for bne.
- JUMP: `pc_source`=10, `pc_write`=1.
- JAL:
  - `pc_source`=10, `pc_write`=1.
  - `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. The PC already holds PC+4, so $31 receives PC+4.
- JR: `pc_source`=11, `pc_write`=1.
- MEMWB, MEMWR (on completion), RWB, IWB, BRANCH, JUMP, JAL and JR are terminal: the next state is FETCH.

## Timing
- Instruction latency with `mem_ready` always high:
  - beq/bne/j/jal/jr: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on `mem_ready` adds 1 cycle.
- `instr_count` increments by 1 on the clock edge that leaves a terminal state.
  - It wraps to 0 after 2^CNT_WIDTH−1.
  - Illegal instructions are not counted.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `rst` high:
  - Next state is FETCH and `instr_count` becomes 0.
  - All outputs are 0 while `rst` is sampled high, including `state`=0 (FETCH).
  - Reset in mid-operation aborts the instruction in progress (pending memory requests included) with no PC or register write.
  - The first request after reset is a FETCH `mem_read` in the cycle after `rst` falls.

## Test plan
- Reset, then `add` inst 0x012A4020 with `mem_ready`=1 → states 0,1,6,7. RWB asserts `reg_write`=1, `reg_dst`=01. `instr_count`=1 after the 4th edge.
- `lw` 0x8D090004 with `mem_ready` low for 3 cycles in MEMRD → `mem_read`=1 and `iord`=1 held for 4 cycles. Instruction totals 8 cycles; MEMWB has `mem_to_reg`=01.
- `beq` 0x11090003 with `alu_zero`=1 → `pc_write`=1 in BRANCH. With `alu_zero`=0 → `pc_write`=0. Both are counted and take 3 cycles.
- `jal` 0x0C000010 → JAL asserts `reg_dst`=10, `mem_to_reg`=10, `pc_source`=10, `pc_write`=1.
- Opcode 0x3F → `illegal` pulses 1 cycle in DECODE, the FSM returns to FETCH, `instr_count` is unchanged.
- Assert `rst` during MEMWR of `sw` → next cycle `state`=0, `mem_write`=0, `instr_count`=0. With CNT_WIDTH=4, 16 retirements wrap the counter to 0.
